// File: rtl/spi_tx_arbiter_if.sv
// Bundle between the per-channel word sources, the arbiter and the SPI serializer.
// The master side is the arbiter; the slave side is the sources plus serializer.
interface spi_tx_arbiter_if #(
  parameter int unsigned N_CH = 4
);
  localparam int unsigned IDW = $clog2(N_CH);

  logic [N_CH-1:0]    REQ;
  logic [16*N_CH-1:0] DATA_IN;
  logic [N_CH-1:0]    ACK;
  logic [15:0]        DATA;
  logic               ENA;
  logic               BUSY;
  logic [IDW-1:0]     GRANT_ID;
  logic               ACTIVE;
  logic               ERR;

  modport master (
    input  REQ, DATA_IN, BUSY,
    output ACK, DATA, ENA, GRANT_ID, ACTIVE, ERR
  );

  modport slave (
    output REQ, DATA_IN, BUSY,
    input  ACK, DATA, ENA, GRANT_ID, ACTIVE, ERR
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin scheduler sharing one SPI serializer between N_CH word sources,
// with a start timeout for a serializer that never raises BUSY.
module spi_tx_arbiter #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned GAP      = 2,
  parameter int unsigned START_TO = 8
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  spi_tx_arbiter_if.master  bus
);

  localparam int unsigned IDW = $clog2(N_CH);
  localparam int unsigned DW  = 16;
  localparam int unsigned TW  = 8;
  localparam int unsigned GW  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  grant_id;
  logic [DW-1:0]   data;
  logic [N_CH-1:0] ack;
  logic            ena;
  logic            active;
  logic            err;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;

  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  idx;
  logic            any_req;
  logic [DW-1:0]   win_data;
  logic            gap_done;

  // First requester found searching upward from last+1, wrapping at N_CH
  always_comb begin
    winner  = last;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = IDW'((32'(last) + i) % N_CH);
      if (!any_req && bus.REQ[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (winner == IDW'(k)) win_data = bus.DATA_IN[DW*k +: DW];
    end
  end

  // GAP state always lasts at least one cycle, even with GAP = 0
  assign gap_done = ({1'b0, gap_cnt} + 5'd1) >= 5'(GAP);

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      last     <= IDW'(N_CH - 1);
      grant_id <= '0;
      data     <= '0;
      ack      <= '0;
      ena      <= 1'b0;
      active   <= 1'b0;
      err      <= 1'b0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      ena <= 1'b0;
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (any_req && !bus.BUSY) begin
            state    <= S_LOAD;
            data     <= win_data;
            grant_id <= winner;
            last     <= winner;
            ena      <= 1'b1;
            ack      <= N_CH'(1) << winner;
            active   <= 1'b1;
          end
        end
        S_LOAD: begin
          state  <= S_WAIT_START;
          to_cnt <= '0;
        end
        S_WAIT_START: begin
          // Only a BUSY rise counts as a start; the word is lost on timeout
          if (bus.BUSY) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt == TW'(START_TO - 1)) begin
            err     <= 1'b1;
            state   <= S_GAP;
            gap_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.BUSY) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            state  <= S_IDLE;
            active <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ACK      = ack;
  assign bus.DATA     = data;
  assign bus.ENA      = ena;
  assign bus.GRANT_ID = grant_id;
  assign bus.ACTIVE   = active;
  assign bus.ERR      = err;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: table of grant vectors checked through a scoreboard,
// plus hand-written timeout, busy-at-idle and reset-mid-word sequences.
module tb_spi_tx_arbiter;

  localparam int unsigned N_CH     = 4;
  localparam int unsigned GAP      = 2;
  localparam int unsigned START_TO = 8;
  localparam int          NVEC     = 12;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  ch;
    logic [15:0] word;
  } vec_t;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] word;
  } exp_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic busy_auto = 1'b0;
  logic busy_man  = 1'b0;
  logic auto_en   = 1'b0;

  always #5 clk = ~clk;

  spi_tx_arbiter_if #(.N_CH(N_CH)) bus ();
  assign bus.BUSY = busy_auto | busy_man;

  spi_tx_arbiter #(
    .N_CH    (N_CH),
    .GAP     (GAP),
    .START_TO(START_TO)
  ) dut (
    .SYS_CLK(clk),
    .RST    (rst_n),
    .bus    (bus)
  );

  int          n_tests    = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          ena_count  = 0;
  int          last_ena   = -1;
  int          fall_cycle = -100;
  logic        prev_busy  = 1'b0;
  logic [15:0] prev_data  = '0;
  bit          chk_gap    = 1'b0;
  bit          gap_armed  = 1'b0;
  exp_t        sb[$];
  vec_t        vecs[NVEC];

  // Serializer model: BUSY high for 16 cycles starting 2 cycles after ENA
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && bus.ENA) begin
        @(posedge clk);
        @(posedge clk);
        #1 busy_auto = 1'b1;
        repeat (16) @(posedge clk);
        #1 busy_auto = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle, sampled at the falling edge, with the grant monitor
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (prev_busy && !bus.BUSY) begin
      fall_cycle = cyc;
      gap_armed  = chk_gap && auto_en;
    end
    prev_busy = bus.BUSY;
    if (bus.ENA || bus.ACK != '0)
      check("ack_onehot_with_ena", 64'($onehot(bus.ACK)), 64'(bus.ENA));
    if (bus.ENA) begin
      ena_count++;
      last_ena = cyc;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_grant: got channel %0d, expected no grant", bus.GRANT_ID);
      end else begin
        e = sb.pop_front();
        check("grant_id", 64'(bus.GRANT_ID), 64'(e.ch));
        check("data",     64'(bus.DATA),     64'(e.word));
        check("ack",      64'(bus.ACK),      64'(4'b0001 << e.ch));
      end
      // BUSY low is seen at the edge closing its first low cycle; ENA is GAP+1 cycles later
      if (gap_armed) begin
        check("gap_to_next_ena", 64'(cyc - fall_cycle - 1), 64'(GAP + 1));
        gap_armed = 1'b0;
      end
    end
    if (rst_n && !bus.ENA && bus.DATA != prev_data) begin
      n_tests++;
      n_fail++;
      $display("FAIL data_stable: got %0h, expected %0h", bus.DATA, prev_data);
    end
    prev_data = bus.DATA;
  endtask

  task automatic drive_vec(input logic [3:0] req, input logic [1:0] ch, input logic [15:0] word);
    exp_t e;
    for (int k = 0; k < 4; k++)
      bus.DATA_IN[16*k +: 16] = (k == int'(ch)) ? word : word ^ 16'(32'h1111 * (k + 1));
    bus.REQ = req;
    e.ch    = ch;
    e.word  = word;
    sb.push_back(e);
  endtask

  task automatic wait_ena(input string name);
    int start;
    start = ena_count;
    for (int i = 0; i < 80 && ena_count == start; i++) step();
    n_tests++;
    if (ena_count == start) begin
      n_fail++;
      $display("FAIL %s: got no ENA within 80 cycles, expected a grant", name);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && (bus.ACTIVE || bus.BUSY); i++) step();
    check(name, 64'(bus.ACTIVE | bus.BUSY), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ena"},      64'(bus.ENA),      64'd0);
    check({tag, "_ack"},      64'(bus.ACK),      64'd0);
    check({tag, "_data"},     64'(bus.DATA),     64'd0);
    check({tag, "_grant_id"}, 64'(bus.GRANT_ID), 64'd0);
    check({tag, "_active"},   64'(bus.ACTIVE),   64'd0);
    check({tag, "_err"},      64'(bus.ERR),      64'd0);
  endtask

  initial begin
    int   enas;
    int   drop;
    logic err_early;

    vecs[0]  = '{4'b0001, 2'd0, 16'hA55A};
    vecs[1]  = '{4'b1111, 2'd1, 16'h1357};
    vecs[2]  = '{4'b1111, 2'd2, 16'h2468};
    vecs[3]  = '{4'b1111, 2'd3, 16'hFFFF};
    vecs[4]  = '{4'b1111, 2'd0, 16'h8001};
    vecs[5]  = '{4'b1111, 2'd1, 16'h7FFE};
    vecs[6]  = '{4'b1010, 2'd3, 16'h3C3C};
    vecs[7]  = '{4'b1010, 2'd1, 16'hC3C3};
    vecs[8]  = '{4'b1010, 2'd3, 16'h5555};
    vecs[9]  = '{4'b0100, 2'd2, 16'hAAAA};
    vecs[10] = '{4'b1001, 2'd3, 16'h0F0F};
    vecs[11] = '{4'b1001, 2'd0, 16'hF0F0};

    bus.REQ     = '0;
    bus.DATA_IN = '0;
    #1 check_reset_outputs("reset");
    step();
    step();
    rst_n   = 1'b1;
    auto_en = 1'b1;
    step();
    check("idle_after_reset", 64'(bus.ACTIVE), 64'd0);

    // Grant sequence: single channel, round robin, skipping idle channels
    chk_gap = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive_vec(vecs[i].req, vecs[i].ch, vecs[i].word);
      wait_ena("vector_grant");
    end
    bus.REQ = '0;
    chk_gap = 1'b0;
    wait_idle("idle_after_vectors");

    // Start timeout: serializer never answers
    auto_en = 1'b0;
    step();
    drive_vec(4'b0010, 2'd1, 16'hBEEF);
    wait_ena("timeout_grant");
    drive_vec(4'b0100, 2'd2, 16'h5AA5);
    err_early = 1'b0;
    repeat (START_TO) begin
      step();
      if (bus.ERR) err_early = 1'b1;
    end
    check("err_before_timeout", 64'(err_early), 64'd0);
    step();
    check("err_at_timeout", 64'(bus.ERR), 64'd1);
    auto_en = 1'b1;
    wait_ena("grant_after_timeout");
    bus.REQ = '0;
    check("err_sticky", 64'(bus.ERR), 64'd1);
    wait_idle("idle_after_timeout");

    // BUSY already high while idle: hold off until it drops
    busy_man = 1'b1;
    step();
    drive_vec(4'b0100, 2'd2, 16'h0F0F);
    enas = ena_count;
    repeat (6) step();
    check("no_ena_while_busy", 64'(ena_count), 64'(enas));
    busy_man = 1'b0;
    drop     = cyc;
    wait_ena("grant_after_busy_drop");
    bus.REQ = '0;
    check("ena_one_cycle_after_busy_low", 64'(last_ena), 64'(drop + 1));
    wait_idle("idle_after_busy_drop");

    // Reset while the serializer is mid-word
    drive_vec(4'b0010, 2'd1, 16'hC3C3);
    wait_ena("grant_before_reset");
    bus.REQ = '0;
    repeat (5) step();
    check("in_word_before_reset", 64'(bus.ACTIVE & bus.BUSY), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midword_reset");
    step();
    step();
    rst_n = 1'b1;
    drive_vec(4'b1111, 2'd0, 16'h1234);
    wait_ena("grant_after_reset");
    bus.REQ = '0;
    check("grant_waits_for_busy_low", 64'(last_ena), 64'(fall_cycle + 1));
    wait_idle("idle_at_end");
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
